// File: rtl/me_pkg.sv
// Shared definitions for the MEM pipeline stage: bus field offsets, access
// size encodings, FSM states and the misalignment rule.
package me_pkg;

  localparam int ME_XLEN        = 32;
  localparam int ME_MAX_DISCARD = 3;

  // EX->ME bus, low fields; the three XLEN-wide fields sit above EX_RKD_LSB.
  localparam int EX_DEST_LSB = 0;
  localparam int EX_GRWE_BIT = 5;
  localparam int EX_SIGN_BIT = 6;
  localparam int EX_SIZE_LSB = 7;
  localparam int EX_WE_BIT   = 9;
  localparam int EX_EN_BIT   = 10;
  localparam int EX_RKD_LSB  = 11;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } me_state_e;

  function automatic int dcnt_width(input int max_discard);
    return $clog2(max_discard + 1);
  endfunction

  // Any size other than byte/half is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/me_lane_align.sv
// Byte-lane steering for the data bus: load extract/extend and store
// strobe/data replication.
module me_lane_align
  import me_pkg::*;
#(
  parameter int XLEN = ME_XLEN
) (
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  input  logic [XLEN-1:0]   rdata_i,
  input  logic [XLEN-1:0]   rkd_i,
  output logic [XLEN-1:0]   load_data_o,
  output logic [XLEN/8-1:0] wstrb_o,
  output logic [XLEN-1:0]   wdata_o
);

  localparam int NB = XLEN / 8;
  localparam logic [NB-1:0] STRB_B = {{(NB-1){1'b0}}, 1'b1};
  localparam logic [NB-1:0] STRB_H = {{(NB-2){1'b0}}, 2'b11};

  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  always_comb begin
    byte_shift = rdata_i >> {addr_lo_i, 3'b000};
    half_shift = rdata_i >> {addr_lo_i[1], 4'b0000};
    lane_b     = byte_shift[7:0];
    lane_h     = half_shift[15:0];
    case (size_i)
      SIZE_B: begin
        load_data_o = {{(XLEN-8){sign_i & lane_b[7]}}, lane_b};
        wstrb_o     = STRB_B << addr_lo_i;
        wdata_o     = {(XLEN/8){rkd_i[7:0]}};
      end
      SIZE_H: begin
        load_data_o = {{(XLEN-16){sign_i & lane_h[15]}}, lane_h};
        wstrb_o     = STRB_H << addr_lo_i;
        wdata_o     = {(XLEN/16){rkd_i[15:0]}};
      end
      default: begin
        load_data_o = rdata_i;
        wstrb_o     = {NB{1'b1}};
        wdata_o     = rkd_i;
      end
    endcase
  end

endmodule

// File: rtl/me_stage_mem_chk.sv
// Simulation checks for the MEM stage: the discard counter must never be
// asked to grow past its ceiling.
module me_stage_mem_chk (
  input logic clk_i,
  input logic reset_i,
  input logic dc_inc_i,
  input logic dc_dec_i,
  input logic dc_at_max_i
);

  a_discard_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(dc_inc_i && !dc_dec_i && dc_at_max_i));

endmodule

// File: rtl/me_stage_mem.sv
// MEM pipeline stage: issues loads/stores on the req/addr_ok/data_ok bus,
// aligns load data, and drops responses that belong to flushed accesses.
module me_stage_mem
  import me_pkg::*;
#(
  parameter int XLEN        = ME_XLEN,
  parameter int MAX_DISCARD = ME_MAX_DISCARD,
  parameter int EX_BUS_W    = 3*XLEN+11,
  parameter int WB_BUS_W    = 2*XLEN+6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                ex_to_me_valid,
  output logic                me_allow_in,
  input  logic [EX_BUS_W-1:0] ex_to_me_bus,
  input  logic                wb_allow_in,
  output logic                me_to_wb_valid,
  output logic [WB_BUS_W-1:0] me_to_wb_bus,
  output logic                me_ale,
  output logic [4:0]          me_dest,
  output logic [XLEN-1:0]     me_fwd_res,
  output logic                me_fwd_stall,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [XLEN/8-1:0]   data_wstrb,
  output logic [XLEN-1:0]     data_addr,
  output logic [XLEN-1:0]     data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [XLEN-1:0]     data_rdata
);

  localparam int DCNT_W = dcnt_width(MAX_DISCARD);
  localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(MAX_DISCARD);
  localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

  logic [XLEN-1:0] in_pc, in_addr, in_rkd;
  logic            in_en, in_we, in_sign, in_gr_we, in_ale;
  logic [1:0]      in_size;
  logic [4:0]      in_dest;

  assign in_pc    = ex_to_me_bus[EX_RKD_LSB+2*XLEN +: XLEN];
  assign in_addr  = ex_to_me_bus[EX_RKD_LSB+XLEN +: XLEN];
  assign in_rkd   = ex_to_me_bus[EX_RKD_LSB +: XLEN];
  assign in_en    = ex_to_me_bus[EX_EN_BIT];
  assign in_we    = ex_to_me_bus[EX_WE_BIT];
  assign in_size  = ex_to_me_bus[EX_SIZE_LSB +: 2];
  assign in_sign  = ex_to_me_bus[EX_SIGN_BIT];
  assign in_gr_we = ex_to_me_bus[EX_GRWE_BIT];
  assign in_dest  = ex_to_me_bus[EX_DEST_LSB +: 5];
  assign in_ale   = in_en && is_misaligned(in_size, in_addr[1:0]);

  me_state_e         state_q, state_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [XLEN-1:0]   pc_q, addr_q, rkd_q;
  logic              en_q, we_q, sign_q, gr_we_q, ale_q;
  logic [1:0]        size_q;
  logic [4:0]        dest_q;

  logic            resp_live, ready_go, accept, dc_inc, dc_dec;
  logic [XLEN-1:0] load_data, final_result;

  me_lane_align #(.XLEN(XLEN)) u_align (
    .addr_lo_i   (addr_q[1:0]),
    .size_i      (size_q),
    .sign_i      (sign_q),
    .rdata_i     (data_rdata),
    .rkd_i       (rkd_q),
    .load_data_o (load_data),
    .wstrb_o     (data_wstrb),
    .wdata_o     (data_wdata)
  );

  // A response only belongs to the in-stage access once all killed ones have drained.
  assign resp_live    = data_data_ok && (dcnt_q == DCNT_ZERO);
  assign ready_go     = (state_q == ST_DONE) || ((state_q == ST_WAIT) && resp_live);
  assign me_allow_in  = flush || !valid_q || (ready_go && wb_allow_in);
  assign accept       = ex_to_me_valid && me_allow_in && !flush;
  assign final_result = (state_q == ST_WAIT) ? load_data : result_q;

  assign dc_inc = flush && valid_q &&
                  (((state_q == ST_REQ) && data_addr_ok) || ((state_q == ST_WAIT) && !resp_live));
  assign dc_dec = data_data_ok && (dcnt_q != DCNT_ZERO);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;
    if (flush) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      result_d = in_addr;
      if (!in_en || in_ale) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_REQ;
      end
    end else if (ready_go && wb_allow_in) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (data_addr_ok) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (resp_live) begin
            state_d  = ST_DONE;
            result_d = load_data;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    dcnt_d = dcnt_q;
    if (dc_inc && !dc_dec) begin
      if (dcnt_q != DCNT_MAX) begin
        dcnt_d = dcnt_q + DCNT_ONE;
      end else begin
        dcnt_d = dcnt_q;
      end
    end else if (dc_dec && !dc_inc) begin
      dcnt_d = dcnt_q - DCNT_ONE;
    end else begin
      dcnt_d = dcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= {XLEN{1'b0}};
      dcnt_q   <= DCNT_ZERO;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // Instruction fields; a misaligned access never writes the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= {XLEN{1'b0}};
      addr_q  <= {XLEN{1'b0}};
      rkd_q   <= {XLEN{1'b0}};
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      sign_q  <= 1'b0;
      gr_we_q <= 1'b0;
      ale_q   <= 1'b0;
      dest_q  <= 5'd0;
    end else if (accept) begin
      pc_q    <= in_pc;
      addr_q  <= in_addr;
      rkd_q   <= in_rkd;
      en_q    <= in_en;
      we_q    <= in_we;
      size_q  <= in_size;
      sign_q  <= in_sign;
      gr_we_q <= in_gr_we && !in_ale;
      ale_q   <= in_ale;
      dest_q  <= in_dest;
    end
  end

  assign data_req       = valid_q && (state_q == ST_REQ);
  assign data_wr        = we_q;
  assign data_size      = size_q;
  assign data_addr      = addr_q;
  assign me_to_wb_valid = valid_q && ready_go && !flush;
  assign me_to_wb_bus   = {pc_q, gr_we_q, dest_q, final_result};
  assign me_ale         = valid_q && ale_q;
  assign me_dest        = (valid_q && gr_we_q) ? dest_q : 5'd0;
  assign me_fwd_res     = final_result;
  assign me_fwd_stall   = valid_q && en_q && !we_q &&
                          ((state_q == ST_REQ) || (state_q == ST_WAIT)) && !resp_live;

  me_stage_mem_chk u_chk (
    .clk_i       (clk),
    .reset_i     (reset),
    .dc_inc_i    (dc_inc),
    .dc_dec_i    (dc_dec),
    .dc_at_max_i (dcnt_q == DCNT_MAX)
  );

endmodule

// File: tb/tb_me_stage_mem.sv
// Directed plus randomized bench for me_stage_mem with an arithmetic
// reference model for load extension and store lane steering.
module tb_me_stage_mem;

  localparam int XLEN     = 32;
  localparam int EX_BUS_W = 3*XLEN+11;
  localparam int WB_BUS_W = 2*XLEN+6;
  localparam int WB_GRWE  = XLEN+5;

  logic                clk = 1'b0;
  logic                reset, flush, ex_to_me_valid, me_allow_in, wb_allow_in;
  logic [EX_BUS_W-1:0] ex_to_me_bus;
  logic                me_to_wb_valid, me_ale, me_fwd_stall;
  logic [WB_BUS_W-1:0] me_to_wb_bus;
  logic [4:0]          me_dest;
  logic [XLEN-1:0]     me_fwd_res, data_addr, data_wdata, data_rdata;
  logic                data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]          data_size;
  logic [3:0]          data_wstrb;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  me_stage_mem dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_to_me_valid(ex_to_me_valid), .me_allow_in(me_allow_in), .ex_to_me_bus(ex_to_me_bus),
    .wb_allow_in(wb_allow_in), .me_to_wb_valid(me_to_wb_valid), .me_to_wb_bus(me_to_wb_bus),
    .me_ale(me_ale), .me_dest(me_dest), .me_fwd_res(me_fwd_res), .me_fwd_stall(me_fwd_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [EX_BUS_W-1:0] make_bus(input logic [31:0] pc, input logic [31:0] alu,
      input logic [31:0] rkd, input logic en, input logic we, input logic [1:0] sz,
      input logic sg, input logic grwe, input logic [4:0] dest);
    return {pc, alu, rkd, en, we, sz, sg, grwe, dest};
  endfunction

  // Reference model: pick the addressed lane with plain arithmetic, then extend.
  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
      input logic [1:0] sz, input logic sg);
    longint v;
    int off;
    if (sz == 2'd0) begin
      off = int'(a[1:0]);
      v = (longint'(rd) >> (8*off)) & 64'hFF;
      if (sg && v > 127) v = v - 256;
    end else if (sz == 2'd1) begin
      off = a[1] ? 2 : 0;
      v = (longint'(rd) >> (8*off)) & 64'hFFFF;
      if (sg && v > 32767) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic [1:0] sz);
    int s;
    if (sz == 2'd0) s = 1 << a[1:0];
    else if (sz == 2'd1) s = 3 << a[1:0];
    else s = 15;
    return s[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] rkd, input logic [1:0] sz);
    longint v;
    if (sz == 2'd0) v = longint'(rkd & 32'hFF) * 64'h0101_0101;
    else if (sz == 2'd1) v = longint'(rkd & 32'hFFFF) * 64'h0001_0001;
    else v = longint'(rkd);
    return v[31:0];
  endfunction

  function automatic logic exp_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  task automatic alu_txn(input logic [31:0] pc, input logic [31:0] res, input logic grwe,
      input logic [4:0] dest);
    ex_to_me_bus = make_bus(pc, res, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, grwe, dest);
    ex_to_me_valid = 1'b1;
    mid(); check("alu_allow_in", me_allow_in, 1'b1);
    tick(); ex_to_me_valid = 1'b0;
    mid();
    check("alu_wb_valid", me_to_wb_valid, 1'b1);
    check("alu_wb_bus", me_to_wb_bus, {pc, grwe, dest, res});
    check("alu_no_req", data_req, 1'b0);
    check("alu_dest", me_dest, grwe ? dest : 5'd0);
    check("alu_fwd_res", me_fwd_res, res);
    tick();
  endtask

  task automatic mem_txn(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rkd,
      input logic we, input logic [1:0] sz, input logic sg, input logic [4:0] dest,
      input logic [31:0] rd, input int aok, input int dok, input logic wb_stall);
    logic is_ld;
    logic [31:0] ld;
    is_ld = !we;
    ld = exp_load(rd, addr, sz, sg);
    ex_to_me_bus = make_bus(pc, addr, rkd, 1'b1, we, sz, sg, is_ld, dest);
    ex_to_me_valid = 1'b1;
    mid(); check("mem_allow_in", me_allow_in, 1'b1);
    tick(); ex_to_me_valid = 1'b0;
    if (exp_mis(addr, sz)) begin
      mid();
      check("ale_flag", me_ale, 1'b1);
      check("ale_no_req", data_req, 1'b0);
      check("ale_wb_valid", me_to_wb_valid, 1'b1);
      check("ale_gr_we", me_to_wb_bus[WB_GRWE], 1'b0);
      check("ale_dest", me_dest, 5'd0);
      tick();
      return;
    end
    for (int c = 0; c < aok; c++) begin
      mid();
      check("req_hold", {data_req, data_wr, data_size, data_addr}, {1'b1, we, sz, addr});
      check("req_stall", me_fwd_stall, is_ld);
      check("req_wb_valid", me_to_wb_valid, 1'b0);
      tick();
    end
    data_addr_ok = 1'b1;
    mid();
    check("req_fields", {data_req, data_wr, data_size, data_addr}, {1'b1, we, sz, addr});
    check("req_wstrb", data_wstrb, exp_strb(addr, sz));
    check("req_wdata", data_wdata, exp_wdata(rkd, sz));
    check("no_ale", me_ale, 1'b0);
    tick(); data_addr_ok = 1'b0;
    for (int c = 0; c < dok - 1; c++) begin
      mid();
      check("wait_no_req", data_req, 1'b0);
      check("wait_stall", me_fwd_stall, is_ld);
      check("wait_wb_valid", me_to_wb_valid, 1'b0);
      tick();
    end
    data_data_ok = 1'b1;
    data_rdata = rd;
    wb_allow_in = !wb_stall;
    mid();
    check("resp_wb_valid", me_to_wb_valid, 1'b1);
    check("resp_stall", me_fwd_stall, 1'b0);
    check("resp_gr_we", me_to_wb_bus[WB_GRWE], is_ld);
    check("resp_dest", me_dest, is_ld ? dest : 5'd0);
    if (is_ld) check("resp_load", me_to_wb_bus, {pc, 1'b1, dest, ld});
    tick();
    data_data_ok = 1'b0;
    data_rdata = $urandom;
    if (wb_stall) begin
      mid();
      check("hold_wb_valid", me_to_wb_valid, 1'b1);
      check("hold_allow_in", me_allow_in, 1'b0);
      if (is_ld) check("hold_captured", me_fwd_res, ld);
      wb_allow_in = 1'b1;
      tick();
    end
  endtask

  initial begin
    logic [31:0] a, rd, rkd;
    logic [1:0]  sz;
    int kind;
    reset = 1'b1; flush = 1'b0; ex_to_me_valid = 1'b0; ex_to_me_bus = '0;
    wb_allow_in = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    mid();
    check("rst_req", data_req, 1'b0);
    check("rst_wb_valid", me_to_wb_valid, 1'b0);
    check("rst_ale", me_ale, 1'b0);
    check("rst_stall", me_fwd_stall, 1'b0);
    check("rst_dest", me_dest, 5'd0);
    check("rst_allow_in", me_allow_in, 1'b1);
    tick();

    alu_txn(32'h1c00_0000, 32'h0000_0005, 1'b1, 5'd7);
    mem_txn(32'h1c00_0004, 32'h1c00_1003, 32'h0, 1'b0, 2'd0, 1'b1, 5'd4, 32'h80FF_1234, 1, 2, 1'b0);
    mem_txn(32'h1c00_0008, 32'h1c00_1003, 32'h0, 1'b0, 2'd0, 1'b0, 5'd5, 32'h80FF_1234, 1, 2, 1'b0);
    mem_txn(32'h1c00_000c, 32'h1c00_1002, 32'h0000_ABCD, 1'b1, 2'd1, 1'b0, 5'd0, 32'h0, 0, 1, 1'b0);
    mem_txn(32'h1c00_0010, 32'h1c00_1002, 32'h0, 1'b0, 2'd2, 1'b0, 5'd6, 32'h0, 0, 1, 1'b0);
    mem_txn(32'h1c00_0014, 32'h1c00_1002, 32'h0, 1'b0, 2'd1, 1'b1, 5'd8, 32'h8001_7F00, 0, 1, 1'b1);

    // Flush while waiting: the stale response must be swallowed, the next one delivered.
    ex_to_me_bus = make_bus(32'h1c00_0020, 32'h1c00_2000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9);
    ex_to_me_valid = 1'b1;
    tick(); ex_to_me_valid = 1'b0;
    data_addr_ok = 1'b1;
    mid(); check("fl_req", data_req, 1'b1);
    tick(); data_addr_ok = 1'b0;
    flush = 1'b1;
    ex_to_me_valid = 1'b1;
    ex_to_me_bus = make_bus(32'h1c00_0024, 32'h55, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd3);
    mid();
    check("fl_allow_in", me_allow_in, 1'b1);
    check("fl_wb_valid", me_to_wb_valid, 1'b0);
    tick(); flush = 1'b0; ex_to_me_valid = 1'b0;
    mid();
    check("fl_not_latched", me_to_wb_valid, 1'b0);
    check("fl_idle_req", data_req, 1'b0);
    ex_to_me_bus = make_bus(32'h1c00_0028, 32'h1c00_2004, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd10);
    ex_to_me_valid = 1'b1;
    tick(); ex_to_me_valid = 1'b0;
    data_addr_ok = 1'b1;
    mid(); check("fl_new_req", {data_req, data_addr}, {1'b1, 32'h1c00_2004});
    tick(); data_addr_ok = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    mid();
    check("fl_stale_dropped", me_to_wb_valid, 1'b0);
    check("fl_stale_stall", me_fwd_stall, 1'b1);
    tick();
    data_rdata = 32'h1234_5678;
    mid();
    check("fl_new_valid", me_to_wb_valid, 1'b1);
    check("fl_new_data", me_to_wb_bus, {32'h1c00_0028, 1'b1, 5'd10, 32'h1234_5678});
    check("fl_new_stall", me_fwd_stall, 1'b0);
    tick(); data_data_ok = 1'b0;
    mid(); check("fl_drained", me_to_wb_valid, 1'b0);
    tick();

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      sz = 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      rd = $urandom;
      rkd = $urandom;
      if (kind == 0) begin
        alu_txn(32'h1c00_1000 + 32'(4*i), a, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)));
      end else begin
        mem_txn(32'h1c00_1000 + 32'(4*i), a, rkd, kind == 4, sz, 1'($urandom_range(0, 1)),
                kind == 4 ? 5'd0 : 5'($urandom_range(1, 31)), rd,
                $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 3) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
